// File: rtl/config_loader.sv
// config_loader: turns a host word stream (header, addr/data pairs) into one-cycle writes on the tile config bus.
// Defining CONFIG_LOADER_CHECKSUM_EN adds a trailing XOR checksum word that is verified before the load completes.
`timescale 1ns/1ps
module config_loader #(
  parameter logic [15:0] MAGIC     = 16'hCF61,
  parameter logic [15:0] FLAG_MIN  = 16'd4,
  parameter logic [15:0] FLAG_MAX  = 16'd7,
  parameter int unsigned GAP       = 1,
  parameter logic [31:0] IDLE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stream_valid,
  input  logic [31:0] stream_data,
  output logic        stream_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] write_count,
  output logic [2:0]  dbg_state
);

  // Handshake: a word transfers on a rising edge where stream_valid and stream_ready are both 1.
  // stream_ready is a registered decode of the state being entered, so it never depends on stream_valid.

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_ISSUE = 3'd3,
    S_GAP   = 3'd4,
    S_FIN   = 3'd5,
    S_ERR   = 3'd6
`ifdef CONFIG_LOADER_CHECKSUM_EN
    , S_CKSUM = 3'd7
`endif
  } state_t;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CKSUM;
`else
  localparam state_t S_AFTER = S_FIN;
`endif

  localparam logic [3:0] GAP_CYC = 4'(GAP);

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] wc_q, wc_d;
  logic [15:0] n_q, n_d;
  logic [31:0] pair_addr_q, pair_addr_d;
  logic [3:0]  gap_q, gap_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [31:0] chk_q, chk_d;
`endif

  logic xfer;
  logic more;

  assign xfer = stream_valid & ready_q;
  assign more = (wc_q < n_q);

  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    addr_d      = IDLE_ADDR;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    wc_d        = wc_q;
    n_d         = n_q;
    pair_addr_d = pair_addr_q;
    gap_d       = gap_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    chk_d       = chk_q;
`endif
    case (state_q)
      S_HDR: begin
        if (xfer) begin
          if (stream_data[31:16] != MAGIC) begin
            state_d = S_ERR;
          end else begin
            n_d     = stream_data[15:0];
            wc_d    = 16'd0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            chk_d   = stream_data;
`endif
            state_d = (stream_data[15:0] == 16'd0) ? S_AFTER : S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (xfer) begin
          if ((stream_data[31:16] < FLAG_MIN) || (stream_data[31:16] > FLAG_MAX)) begin
            state_d = S_ERR;
          end else begin
            pair_addr_d = stream_data;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            chk_d       = chk_q ^ stream_data;
`endif
            state_d     = S_DATA;
          end
        end
      end
      S_DATA: begin
        // The bus registers load here so the write appears the cycle after the data word transfers.
        if (xfer) begin
          addr_d  = pair_addr_q;
          data_d  = stream_data;
          wc_d    = wc_q + 16'd1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ stream_data;
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (GAP_CYC != 4'd0) begin
          gap_d   = GAP_CYC - 4'd1;
          state_d = S_GAP;
        end else begin
          state_d = more ? S_ADDR : S_AFTER;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = more ? S_ADDR : S_AFTER;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
`ifdef CONFIG_LOADER_CHECKSUM_EN
      S_CKSUM: begin
        if (xfer) begin
          state_d = (stream_data == chk_q) ? S_FIN : S_ERR;
        end
      end
`endif
      S_FIN: begin
        state_d = S_HDR;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase

    // Status flags follow the state being entered so they line up with it on the outputs.
    if (state_d == S_FIN) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (state_d == S_ERR) begin
      busy_d  = 1'b0;
      error_d = 1'b1;
    end
    ready_d = (state_d == S_HDR) || (state_d == S_ADDR) || (state_d == S_DATA)
`ifdef CONFIG_LOADER_CHECKSUM_EN
              || (state_d == S_CKSUM)
`endif
              ;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HDR;
      ready_q     <= 1'b0;
      addr_q      <= IDLE_ADDR;
      data_q      <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wc_q        <= 16'd0;
      n_q         <= 16'd0;
      pair_addr_q <= 32'h0;
      gap_q       <= 4'd0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      chk_q       <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      wc_q        <= wc_d;
      n_q         <= n_d;
      pair_addr_q <= pair_addr_d;
      gap_q       <= gap_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign stream_ready = ready_q;
  assign config_addr  = addr_q;
  assign config_data  = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign write_count  = wc_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: directed loads plus random loads checked against a pair-list reference model.
`timescale 1ns/1ps
module tb_config_loader;

  localparam logic [15:0] MAGIC = 16'hCF61;
  localparam logic [31:0] IDLE  = 32'h0;
  localparam int          GAP   = 1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stream_valid = 1'b0;
  logic [31:0] stream_data = 32'h0;
  logic        stream_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] write_count;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit prev_act = 1'b0;

  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] la[$];
  logic [31:0] ld[$];

  config_loader dut (
    .clk          (clk),
    .reset        (reset),
    .stream_valid (stream_valid),
    .stream_data  (stream_data),
    .stream_ready (stream_ready),
    .config_addr  (config_addr),
    .config_data  (config_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .write_count  (write_count),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: every non-idle bus cycle must be the next expected pair, last one cycle, and follow its data word
  always @(negedge clk) begin : bus_mon
    logic [63:0] e;
    int c;
    if (mon_en) begin
      if (config_addr !== IDLE) begin
        chk("wr_one_cycle", {63'd0, prev_act}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", config_addr, IDLE);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("wr_pair", {config_addr, config_data}, e);
          chk("wr_latency", cyc, c);
        end
        prev_act = 1'b1;
      end else begin
        prev_act = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic send_word(input logic [31:0] w, input int stall);
    bit ok;
    if (stall == 1 || (stall == 2 && $urandom_range(0, 1) == 1)) begin
      stream_valid = 1'b0;
      @(posedge clk); #1;
    end
    stream_valid = 1'b1;
    stream_data  = w;
    ok = 1'b0;
    for (int b = 0; b < 40; b++) begin
      if (stream_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    stream_valid = 1'b0;
    chk("ready_wait", {63'd0, ok}, 64'd1);
  endtask

  task automatic do_reset(input bit v, input logic [31:0] w);
    reset = 1'b1;
    stream_valid = v;
    stream_data = w;
    @(posedge clk); #1;
    reset = 1'b0;
    stream_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", stream_ready, 0);
    chk("rst_addr", config_addr, IDLE);
    chk("rst_data", config_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_wc", write_count, 0);
    @(posedge clk); #1;
    chk("rst_ready_hdr", stream_ready, 1);
  endtask

  // Reference model: a load is the header plus the pair list la/ld; each legal pair becomes one write,
  // the first illegal flag or a bad header ends the load in error.
  task automatic run_load(input logic [31:0] hdr, input int stall, input bit ck_bad);
    logic [31:0] ck;
    logic [15:0] fl;
    int n;
    int nw;
    int last_acc;
    bit err;
    bit hdr_bad;
    n = int'(hdr[15:0]);
    ck = hdr;
    nw = 0;
    last_acc = -1;
    hdr_bad = (hdr[31:16] != MAGIC);
    err = hdr_bad;
    send_word(hdr, stall);
    @(negedge clk);
    if (hdr_bad) begin
      chk("hdr_error", error, 1);
      chk("hdr_err_ready", stream_ready, 0);
      chk("hdr_err_busy", busy, 0);
    end else begin
      chk("hdr_busy", busy, 64'(n > 0 || CK_EN));
      chk("hdr_done", done, 64'(!(n > 0 || CK_EN)));
      chk("hdr_wc", write_count, 0);
    end
    for (int i = 0; i < n && !err; i++) begin
      fl = la[i][31:16];
      send_word(la[i], stall);
      ck = ck ^ la[i];
      if (fl < 16'd4 || fl > 16'd7) begin
        err = 1'b1;
        @(negedge clk);
        chk("flag_error", error, 1);
        chk("flag_err_ready", stream_ready, 0);
        chk("flag_err_busy", busy, 0);
        chk("flag_err_done", done, 0);
        chk("flag_err_addr", config_addr, IDLE);
      end else begin
        send_word(ld[i], stall);
        ck = ck ^ ld[i];
        exp_q.push_back({la[i], ld[i]});
        exp_cyc_q.push_back(cyc);
        if (stall == 0 && last_acc >= 0) chk("throughput", cyc - last_acc, 3 + GAP);
        last_acc = cyc;
        nw++;
      end
    end
`ifdef CONFIG_LOADER_CHECKSUM_EN
    if (!err) begin
      send_word(ck ^ (ck_bad ? 32'h1 : 32'h0), stall);
      if (ck_bad) begin
        err = 1'b1;
        @(negedge clk);
        chk("ck_error", error, 1);
        chk("ck_err_done", done, 0);
        chk("ck_err_ready", stream_ready, 0);
      end
    end
`endif
    if (!err) begin
      for (int b = 0; b < 40 && done !== 1'b1; b++) @(negedge clk);
      chk("load_done", done, 1);
      chk("load_busy", busy, 0);
      chk("load_error", error, 0);
    end
    if (!hdr_bad) chk("load_wc", write_count, nw);
    repeat (3) @(negedge clk);
    chk("wr_missing", exp_q.size(), 0);
    chk("bus_idle_after", config_addr, IDLE);
  endtask

  initial begin
    do_reset(1'b0, 32'h0);
    mon_en = 1'b1;

    // single pair
    la = '{32'h00070003};
    ld = '{32'h0000000A};
    run_load(32'hCF610001, 0, 1'b0);

    // three pairs with valid toggling every cycle
    la = '{32'h00040011, 32'h00050022, 32'h00060033};
    ld = '{32'hDEAD0001, 32'hBEEF0002, 32'hCAFE0003};
    run_load(32'hCF610003, 1, 1'b0);
    chk("done_sticky", done, 1);

    // random legal loads
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 5);
      la.delete();
      ld.delete();
      for (int i = 0; i < n; i++) begin
        la.push_back({16'($urandom_range(4, 7)), 16'($urandom)});
        ld.push_back($urandom);
      end
      run_load({MAGIC, 16'(n)}, k % 3, 1'b0);
    end

    // empty load
    la.delete();
    ld.delete();
    run_load(32'hCF610000, 0, 1'b0);

    // illegal module flag on the second pair
    la = '{32'h00070001, 32'h00030005};
    ld = '{32'h12345678, 32'h00000000};
    run_load(32'hCF610002, 0, 1'b0);
    stream_valid = 1'b1;
    stream_data = 32'h00070002;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      chk("err_sticky_ready", stream_ready, 0);
      chk("err_sticky", error, 1);
    end
    stream_valid = 1'b0;
    do_reset(1'b0, 32'h0);

    // bad magic
    la = '{32'h00040001, 32'h00040002};
    ld = '{32'h1, 32'h2};
    run_load(32'h12340002, 0, 1'b0);
    do_reset(1'b0, 32'h0);

    // reset while the second pair's data word is pending
    la = '{32'h00040101, 32'h00050202};
    ld = '{32'hAAAA0001, 32'hBBBB0002};
    send_word(32'hCF610002, 0);
    send_word(la[0], 0);
    send_word(ld[0], 0);
    exp_q.push_back({la[0], ld[0]});
    exp_cyc_q.push_back(cyc);
    send_word(la[1], 0);
    do_reset(1'b1, ld[1]);
    repeat (4) @(negedge clk);
    chk("midrst_no_write", exp_q.size(), 0);
    chk("midrst_wc", write_count, 0);

    // recovery after reset
    la = '{32'h00060abc};
    ld = '{32'h00000fed};
    run_load(32'hCF610001, 2, 1'b0);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    la = '{32'h0004000A};
    ld = '{32'h0000000D};
    run_load(32'hCF610001, 0, 1'b0);
    run_load(32'hCF610001, 0, 1'b1);
    do_reset(1'b0, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
